// File: rtl/checksum_pkg.sv
// ============================================================================
// checksum_pkg: shared modes, FSM states and default widths for checksum_engine.
// Rev 1.0
// ============================================================================
`default_nettype none

package checksum_pkg;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_COUNT_W = 16;

  typedef enum logic [1:0] {
    MODE_LRC      = 2'd0,
    MODE_XOR      = 2'd1,
    MODE_FLETCHER = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Folds reserved (and Fletcher when not built in) onto LRC.
  function automatic mode_e norm_mode(input logic [1:0] m, input logic fletcher_en);
    mode_e r;
    case (m)
      2'd1:    r = MODE_XOR;
      2'd2:    r = fletcher_en ? MODE_FLETCHER : MODE_LRC;
      default: r = MODE_LRC;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ones_comp_add.sv
// ============================================================================
// ones_comp_add: modulo (2^DATA_W - 1) adder, all-ones result normalised to 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module ones_comp_add #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_wrap;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // End-around carry; cannot overflow again since i_a is already a residue.
  assign w_wrap = w_sum[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, w_sum[DATA_W]};
  assign o_sum  = (&w_wrap) ? '0 : w_wrap;

endmodule

`default_nettype wire

// File: rtl/checksum_engine.sv
// ============================================================================
// checksum_engine: streaming LRC / XOR / Fletcher checksum with held result.
// Macro CHECKSUM_FLETCHER_EN builds in Fletcher mode and the B accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module checksum_engine
  import checksum_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [2*DATA_W-1:0]   sum_data,
  output logic [COUNT_W-1:0]    sum_count
);

`ifdef CHECKSUM_FLETCHER_EN
  localparam logic c_FLETCHER_EN = 1'b1;
`else
  localparam logic c_FLETCHER_EN = 1'b0;
`endif
  localparam logic [DATA_W-1:0]  c_DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] c_CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e               r_state;
  state_e               w_state_next;
  mode_e                r_mode;
  mode_e                w_mode;
  logic [DATA_W-1:0]    r_acc_a;
  logic [DATA_W-1:0]    w_acc_a_next;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   w_count_inc;
  logic [2*DATA_W-1:0]  w_result;
  logic                 w_take;
  logic                 w_hold;

  assign w_hold    = (r_state == ST_HOLD);
  assign in_ready  = ~w_hold;
  assign sum_valid = w_hold;
  // clear wins over a simultaneous beat, so the beat is never taken.
  assign w_take    = in_valid & in_ready & ~clear;

  // The first beat of a frame uses the live mode; later beats use the latch.
  assign w_mode      = (r_state == ST_IDLE) ? norm_mode(mode, c_FLETCHER_EN) : r_mode;
  assign w_count_inc = (&r_count) ? r_count : r_count + c_CNT_ONE;

`ifdef CHECKSUM_FLETCHER_EN
  logic [DATA_W-1:0] r_acc_b;
  logic [DATA_W-1:0] w_fl_a;
  logic [DATA_W-1:0] w_fl_b;

  ones_comp_add #(.DATA_W(DATA_W)) u_add_a (
    .i_a   (r_acc_a),
    .i_b   (in_data),
    .o_sum (w_fl_a)
  );

  ones_comp_add #(.DATA_W(DATA_W)) u_add_b (
    .i_a   (r_acc_b),
    .i_b   (w_fl_a),
    .o_sum (w_fl_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_b <= '0;
    end else if (!w_hold) begin
      if (clear) begin
        r_acc_b <= '0;
      end else if (w_take && w_mode == MODE_FLETCHER) begin
        r_acc_b <= w_fl_b;
      end
    end else if (sum_ready) begin
      r_acc_b <= '0;
    end
  end
`endif

  always_comb begin
    w_acc_a_next = r_acc_a + in_data;
    case (w_mode)
      MODE_XOR:      w_acc_a_next = r_acc_a ^ in_data;
`ifdef CHECKSUM_FLETCHER_EN
      MODE_FLETCHER: w_acc_a_next = w_fl_a;
`endif
      default:       w_acc_a_next = r_acc_a + in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (clear) begin
          w_state_next = ST_IDLE;
        end else if (w_take) begin
          w_state_next = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (sum_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Accumulators freeze in HOLD so the result stays stable until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_a <= '0;
      r_count <= '0;
      r_mode  <= MODE_LRC;
    end else if (!w_hold) begin
      if (clear) begin
        r_acc_a <= '0;
        r_count <= '0;
      end else if (w_take) begin
        r_acc_a <= w_acc_a_next;
        r_count <= w_count_inc;
        if (r_state == ST_IDLE) begin
          r_mode <= w_mode;
        end
      end
    end else if (sum_ready) begin
      r_acc_a <= '0;
      r_count <= '0;
    end
  end

  always_comb begin
    w_result = '0;
    if (w_hold) begin
      case (r_mode)
        MODE_XOR:      w_result[DATA_W-1:0] = r_acc_a;
`ifdef CHECKSUM_FLETCHER_EN
        MODE_FLETCHER: w_result = {r_acc_b, r_acc_a};
`endif
        default:       w_result[DATA_W-1:0] = ~r_acc_a + c_DATA_ONE;
      endcase
    end
  end

  assign sum_data  = w_result;
  assign sum_count = w_hold ? r_count : '0;

endmodule

`default_nettype wire

// File: tb/tb_checksum_engine.sv
// ============================================================================
// tb_checksum_engine: table vectors, corner sequences and random frames vs model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_checksum_engine;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          sum_valid;
  logic          sum_ready;
  logic [2*DW-1:0] sum_data;
  logic [CW-1:0] sum_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] beats [0:31];

  checksum_engine #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_count (sum_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      m;
    int              n;
    logic [0:5][7:0] d;
    int              exp_data;
    int              exp_count;
  } vec_t;

  vec_t tbl [0:8];

`ifdef CHECKSUM_FLETCHER_EN
  localparam bit FL_ON = 1'b1;
`else
  localparam bit FL_ON = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: checksum of beats[0..n-1] straight from the arithmetic definitions.
  function automatic int model_sum(input logic [1:0] m, input int n);
    int s, a, b, em;
    em = int'(m);
    if (em == 3 || (em == 2 && !FL_ON)) em = 0;
    s = 0; a = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      if (em == 0) s = (s + int'(beats[i])) % 256;
      else if (em == 1) s = s ^ int'(beats[i]);
      else begin
        a = (a + int'(beats[i])) % 255;
        b = (b + a) % 255;
      end
    end
    if (em == 0) return (256 - s) % 256;
    if (em == 1) return s;
    return b * 256 + a;
  endfunction

  task automatic drive_beats(input logic [1:0] m, input int n, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        mode = 2'($urandom);
        @(posedge clk); #1;
      end
      check("in_ready_accum", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = beats[i];
      in_last  = last && (i == n - 1);
      mode     = (i == 0) ? m : 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Checks the held result for hold+1 cycles while tempting the DUT with beats.
  task automatic check_hold(input int exp_d, input int exp_c, input int hold);
    check("sum_valid_latency", int'(sum_valid), 1);
    check("sum_data", int'(sum_data), exp_d);
    check("sum_count", int'(sum_count), exp_c);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = 8'h5A;
      @(posedge clk); #1;
      check("bp_valid", int'(sum_valid), 1);
      check("bp_data", int'(sum_data), exp_d);
      check("bp_count", int'(sum_count), exp_c);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Handshake with a last beat offered in the same cycle; it must not be taken.
  task automatic handshake();
    sum_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'h10;
    @(posedge clk); #1;
    sum_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("post_hs_valid", int'(sum_valid), 0);
    check("post_hs_ready", int'(in_ready), 1);
    check("post_hs_data", int'(sum_data), 0);
    check("post_hs_count", int'(sum_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ed;
    logic [1:0] m;

    tbl[0] = '{2'd0, 3, {8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00}, 'h00FA, 3};
    tbl[1] = '{2'd1, 3, {8'hAA, 8'h55, 8'h0F, 8'h00, 8'h00, 8'h00}, 'h00F0, 3};
    tbl[2] = '{2'd1, 2, {8'h07, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 'h0000, 2};
    tbl[3] = '{2'd2, 5, {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h00},
               FL_ON ? 'hC8F0 : 'h0011, 5};
    tbl[4] = '{2'd3, 1, {8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 'h00F0, 1};
    tbl[5] = '{2'd0, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 'h0000, 1};
    tbl[6] = '{2'd2, 2, {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
               FL_ON ? 'h0000 : 'h0002, 2};
    tbl[7] = '{2'd1, 3, {8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00}, 'h003C, 3};
    tbl[8] = '{2'd2, 2, {8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00},
               FL_ON ? 'h0403 : 'h00FD, 2};

    rst_n = 1'b0; clear = 1'b0; mode = 2'd0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; sum_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", int'(sum_valid), 0);
    check("rst_data", int'(sum_data), 0);
    check("rst_count", int'(sum_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < tbl[t].n; i++) beats[i] = tbl[t].d[i];
      drive_beats(tbl[t].m, tbl[t].n, 1'b1, 1'b0);
      check_hold(tbl[t].exp_data, tbl[t].exp_count, (t == 0) ? 5 : 0);
      handshake();
    end

    // Count saturation at 2^CW-1: twenty 0x01 beats.
    for (int i = 0; i < 20; i++) beats[i] = 8'h01;
    drive_beats(2'd0, 20, 1'b1, 1'b0);
    check_hold('h00EC, CNT_MAX, 0);
    handshake();

    // Clear after two beats, then a fresh single-beat LRC frame.
    beats[0] = 8'h44; beats[1] = 8'h21;
    drive_beats(2'd0, 2, 1'b0, 1'b0);
    check("accum_count_zero", int'(sum_count), 0);
    check("accum_data_zero", int'(sum_data), 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_valid", int'(sum_valid), 0);
    beats[0] = 8'h10;
    drive_beats(2'd0, 1, 1'b1, 1'b0);
    check_hold('h00F0, 1, 0);
    handshake();

    // Clear together with a last beat: beat dropped.
    beats[0] = 8'h05;
    drive_beats(2'd0, 1, 1'b0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clear_beat_dropped", int'(sum_valid), 0);
    beats[0] = 8'h10;
    drive_beats(2'd0, 1, 1'b1, 1'b0);
    check_hold('h00F0, 1, 0);
    handshake();

    // Clear in HOLD is ignored.
    beats[0] = 8'h3C;
    drive_beats(2'd1, 1, 1'b1, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("hold_clear_valid", int'(sum_valid), 1);
    check("hold_clear_data", int'(sum_data), 'h003C);
    handshake();

    // Reset while holding a result.
    beats[0] = 8'h77;
    drive_beats(2'd1, 1, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("hold_rst_valid", int'(sum_valid), 0);
    check("hold_rst_data", int'(sum_data), 0);
    check("hold_rst_count", int'(sum_count), 0);
    rst_n = 1'b1;
    check("hold_rst_in_ready", int'(in_ready), 1);

    // Randomized frames with idle gaps and mid-frame mode churn.
    for (int f = 0; f < 30; f++) begin
      m = 2'($urandom);
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) beats[i] = 8'($urandom);
      ed = model_sum(m, n);
      drive_beats(m, n, 1'b1, 1'b1);
      check_hold(ed, (n > CNT_MAX) ? CNT_MAX : n, $urandom_range(0, 2));
      handshake();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/checksum_engine.md
CHECKSUM_ENGINE -- requirements
Module: checksum_engine

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data beat width and the width of each checksum half.
REQ-002 Parameter COUNT_W, default 16, SHALL set the beat-counter width.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 clear  input  1  SHALL abandon the current frame (synchronous).
REQ-006 mode  input  2  SHALL select the algorithm: 0=LRC, 1=XOR, 2=Fletcher, 3=reserved.
REQ-007 in_valid  input  1  SHALL mark in_data/in_last as valid.
REQ-008 in_ready  output  1  SHALL indicate the block accepts a beat.
REQ-009 in_data  input  DATA_W  SHALL carry the data beat.
REQ-010 in_last  input  1  SHALL mark the final beat of a frame.
REQ-011 sum_valid  output  1  SHALL mark the result as valid.
REQ-012 sum_ready  input  1  SHALL indicate the consumer accepts the result.
REQ-013 sum_data  output  2*DATA_W  SHALL carry the result: {B,A} for Fletcher, {0,result} otherwise.
REQ-014 sum_count  output  COUNT_W  SHALL carry the number of beats in the frame.

Function
REQ-015 The FSM SHALL have exactly three states.
  - IDLE -> ACCUM on an accepted non-last beat.
  - IDLE -> HOLD on an accepted last beat.
  - ACCUM -> HOLD on an accepted last beat.
  - HOLD -> IDLE on sum_valid && sum_ready.
REQ-016 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 mode SHALL be latched on the first accepted beat of a frame; mode changes mid-frame SHALL be ignored.
REQ-018 Every accepted beat SHALL be accumulated, including zero-valued and repeated beats.
REQ-019 LRC: accumulator S SHALL update as S = (S + d) mod 2^DATA_W; result A = ((S ^ all-ones) + 1) mod 2^DATA_W.
REQ-020 XOR: accumulator SHALL update as S = S ^ d; result A = S.
REQ-021 Fletcher: A SHALL update as A = (A + d) mod (2^DATA_W - 1), then B = (B + A_new) mod (2^DATA_W - 1).
  - Both A and B start at 0.
  - The residue SHALL be normalised so that the all-ones value maps to 0.
REQ-022 mode 3 SHALL behave as mode 0.
REQ-023 sum_valid SHALL assert the cycle after the last beat is accepted (latency 1).
REQ-024 While sum_valid=1, sum_data and sum_count SHALL remain stable until the handshake.
REQ-025 sum_count SHALL saturate at 2^COUNT_W - 1 and SHALL NOT wrap.
REQ-026 Accumulators SHALL reset to 0 on entry to IDLE.
REQ-027 A frame SHALL NOT be accepted in the same cycle as the HOLD handshake.
REQ-028 clear in IDLE or ACCUM SHALL return the FSM to IDLE with accumulators and count zeroed.
  - clear SHALL take priority over a simultaneous beat, and that beat SHALL be dropped.
REQ-029 clear SHALL be ignored in HOLD; a pending result SHALL never be lost.
REQ-030 Outside HOLD, sum_data and sum_count SHALL read 0.

Reset
REQ-031 On rst_n=0, in any state including mid-frame and HOLD, the following SHALL hold on the next edge:
  - state = IDLE
  - accumulators = 0
  - latched mode = 0
  - sum_valid = 0, sum_data = 0, sum_count = 0
  - in_ready = 1 after rst_n deasserts

Configuration
REQ-032 Macro CHECKSUM_FLETCHER_EN defined SHALL compile in mode 2 and the B accumulator.
REQ-033 Without CHECKSUM_FLETCHER_EN:
  - mode 2 SHALL behave as mode 0.
  - sum_data upper DATA_W bits SHALL be constant 0.
  - no B register SHALL exist.

Structure
REQ-034 Package checksum_pkg SHALL hold:
  - the mode enum (MODE_LRC, MODE_XOR, MODE_FLETCHER, MODE_RSVD)
  - the FSM state enum
  - a localparam for the default widths
REQ-035 One sub-module, ones_comp_add, SHALL implement the mod (2^DATA_W - 1) add with normalisation; it SHALL be instantiated twice under the macro.

Verification
REQ-036 LRC, beats 0x01,0x02,0x03 (last on 0x03) -> sum_data=0x00FA, sum_count=3, sum_valid one cycle after last.
REQ-037 XOR, beats 0xAA,0x55,0x0F -> sum_data=0x00F0; repeated beats 0x07,0x07 in a second frame -> 0x0000, count 2.
REQ-038 Fletcher (macro on), beats 0x61..0x65 ("abcde") -> sum_data=0xC8F0, count 5; macro off, same stimulus -> 0x0011, count 5.
REQ-039 Backpressure: sum_ready held low 5 cycles -> sum_valid, sum_data, sum_count stable and in_ready=0 throughout; IDLE the cycle after the handshake.
REQ-040 Clear and reset:
  - clear after 2 beats, then LRC frame 0x10 (last) -> 0x00F0, count 1.
  - clear together with a beat -> beat dropped.
  - rst_n=0 in HOLD -> sum_valid=0 on the next edge.
